// File: rtl/mux_pkg.sv
// Shared definitions for the mux_n_pipe steering stage.
//   fifo_state_t  : occupancy states of the 2-entry output queue
//   calc_sel_w    : select width for n channels, never below 1
//   sel_in_range  : 1 when sel addresses an existing channel
//   MUX_ENTRY_T   : packed queue entry {data, err} for a given data width
`ifndef MUX_PKG_ENTRY_DEFINED
`define MUX_PKG_ENTRY_DEFINED
`define MUX_ENTRY_T(WD) struct packed { logic [(WD)-1:0] data; logic err; }
`endif

package mux_pkg;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  function automatic int calc_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Written as if/else on purpose: an X/Z select makes the condition
  // unknown, which takes the else branch in simulation and reports the
  // select as out of range. Hardware sees only the compare.
  function automatic bit sel_in_range(input logic [31:0] sel, input int unsigned n);
    bit ok;
    if (sel < n) ok = 1'b1;
    else         ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready queue with registered head output.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : write side; in_ready depends on state only
//   in_data [PW]        : payload written on push
//   out_valid/out_ready : read side; out_valid = queue not empty
//   out_data [PW]       : head entry, straight from a register
module skid_fifo2
  import mux_pkg::*;
#(
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  fifo_state_t   state_reg, state_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic          push, pop;

  assign in_ready  = (state_reg != FIFO_FULL);
  assign out_valid = (state_reg != FIFO_EMPTY);
  assign out_data  = head_reg;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      FIFO_EMPTY: begin
        if (push) begin
          state_next = FIFO_ONE;
          head_next  = in_data;
        end
      end
      FIFO_ONE: begin
        if (push && !pop) begin
          state_next = FIFO_FULL;
          tail_next  = in_data;
        end else if (pop && !push) begin
          state_next = FIFO_EMPTY;
        end else if (push && pop) begin
          // Old head leaves, new word replaces it directly.
          head_next = in_data;
        end
      end
      FIFO_FULL: begin
        if (pop) begin
          state_next = FIFO_ONE;
          head_next  = tail_reg;
        end
      end
      default: state_next = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FIFO_EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way word select feeding a 2-entry valid/ready output queue.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_sel [SEL_W]       : channel select, sampled on push only
//   in_data [N_IN*W]     : flat bus, channel k at [k*W +: W]
//   out_valid/out_ready  : output handshake
//   out_data [W]         : selected word (DEFAULT_VAL on bad select)
//   out_sel_err          : entry came from an out-of-range select
//   err_cnt [CNT_W]      : saturating count of accepted bad selects
//   cnt_clr              : synchronous clear of err_cnt
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int          N_IN        = 4,
  parameter int          W           = 8,
  parameter int          SEL_W       = calc_sel_w(N_IN),
  parameter logic [W-1:0] DEFAULT_VAL = '0,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [N_IN*W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_sel_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);

  typedef `MUX_ENTRY_T(W) entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     chan [N_IN];
  logic             sel_ok;
  logic             push;
  logic             err_inc;
  entry_t           entry_in;
  entry_t           entry_head;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*W +: W];
    end
  endgenerate

  assign sel_ok  = sel_in_range(32'(in_sel), N_IN);
  assign push    = in_valid && in_ready;
  assign err_inc = push && !sel_ok;

  always_comb begin
    entry_in.data = DEFAULT_VAL;
    entry_in.err  = 1'b1;
    if (sel_ok) begin
      entry_in.data = chan[in_sel];
      entry_in.err  = 1'b0;
    end
  end

  // A clear in the same cycle as a new error leaves that error counted.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (cnt_clr)
      err_cnt_next = err_inc ? CNT_W'(1) : '0;
    else if (err_inc && err_cnt_reg != CNT_MAX)
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_reg <= '0;
    else     err_cnt_reg <= err_cnt_next;
  end

  skid_fifo2 #(
    .PW (W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (entry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (entry_head)
  );

  assign out_data    = entry_head.data;
  assign out_sel_err = entry_head.err;
  assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: instance a (N_IN=4, W=8) and
// instance b (N_IN=5, DEFAULT_VAL=EE, CNT_W=2), plus a random soak on b
// against a scoreboard queue.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [1:0]  a_in_sel = '0;
  logic [31:0] a_in_data = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  a_out_data;
  logic        a_out_sel_err, a_cnt_clr = 1'b0;
  logic [15:0] a_err_cnt;

  // instance b
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [2:0]  b_in_sel = '0;
  logic [39:0] b_in_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  b_out_data;
  logic        b_out_sel_err, b_cnt_clr = 1'b0;
  logic [1:0]  b_err_cnt;

  mux_n_pipe #(.N_IN(4), .W(8)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sel_err(a_out_sel_err), .err_cnt(a_err_cnt), .cnt_clr(a_cnt_clr)
  );

  mux_n_pipe #(.N_IN(5), .W(8), .DEFAULT_VAL(8'hEE), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sel_err(b_out_sel_err), .err_cnt(b_err_cnt), .cnt_clr(b_cnt_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0]  sb_q [$];
  logic [8:0]  exp_entry;
  logic [7:0]  held_data;
  logic        held_err, stalled, push, pop;
  logic [1:0]  ref_cnt;
  logic [63:0] rnd;
  int          sel_i;

  initial begin
    // ---- reset state
    step(); step();
    rst = 1'b0;
    step();
    check("rst_a_valid",  64'(a_out_valid), 64'd0);
    check("rst_a_data",   64'(a_out_data), 64'd0);
    check("rst_a_err",    64'(a_out_sel_err), 64'd0);
    check("rst_a_cnt",    64'(a_err_cnt), 64'd0);
    check("rst_a_ready",  64'(a_in_ready), 64'd1);
    check("rst_b_cnt",    64'(b_err_cnt), 64'd0);

    // ---- basic steering, one word per cycle
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 2'(k);
      step();
      check("basic_valid", 64'(a_out_valid), 64'd1);
      check("basic_data",  64'(a_out_data), 64'(8'h11 * (k + 1)));
      check("basic_err",   64'(a_out_sel_err), 64'd0);
      $display("basic: sel=%0d out_data=%0h", k, a_out_data);
    end
    a_in_valid = 1'b0;
    step();
    check("basic_drain", 64'(a_out_valid), 64'd0);

    // ---- backpressure
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_sel = 2'd1;
    step();
    check("bp_data1",  64'(a_out_data), 64'h22);
    check("bp_ready1", 64'(a_in_ready), 64'd1);
    a_in_sel = 2'd2;
    step();
    check("bp_ready2", 64'(a_in_ready), 64'd0);
    check("bp_hold2",  64'(a_out_data), 64'h22);
    a_in_valid = 1'b0;
    step(); step();
    check("bp_hold3",  64'(a_out_data), 64'h22);
    a_out_ready = 1'b1;
    step();
    check("bp_next",   64'(a_out_data), 64'h33);
    check("bp_valid",  64'(a_out_valid), 64'd1);
    check("bp_ready3", 64'(a_in_ready), 64'd1);
    step();
    check("bp_empty",  64'(a_out_valid), 64'd0);
    $display("backpressure: sequence 22,33 delivered");

    // ---- reset mid-operation with a full queue
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_sel = 2'd0; step();
    a_in_sel = 2'd3; step();
    check("mid_full", 64'(a_in_ready), 64'd0);
    rst = 1'b1; a_in_sel = 2'd1;
    step();
    rst = 1'b0; a_in_valid = 1'b0;
    check("mid_valid", 64'(a_out_valid), 64'd0);
    check("mid_ready", 64'(a_in_ready), 64'd1);
    check("mid_cnt",   64'(a_err_cnt), 64'd0);
    check("mid_data",  64'(a_out_data), 64'd0);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_sel = 2'd2;
    step();
    a_in_valid = 1'b0;
    check("mid_lat_valid", 64'(a_out_valid), 64'd1);
    check("mid_lat_data",  64'(a_out_data), 64'h33);
    $display("reset mid-op: queue discarded, next push out=%0h", a_out_data);

    // ---- out-of-range selects on instance b
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_sel = 3'd6;
    step();
    check("oor6_data", 64'(b_out_data), 64'hEE);
    check("oor6_err",  64'(b_out_sel_err), 64'd1);
    check("oor6_cnt",  64'(b_err_cnt), 64'd1);
    b_in_sel = 3'd7;
    step();
    check("oor7_data", 64'(b_out_data), 64'hEE);
    check("oor7_err",  64'(b_out_sel_err), 64'd1);
    check("oor7_cnt",  64'(b_err_cnt), 64'd2);
    b_in_sel = 3'd4;
    step();
    check("sel4_data", 64'(b_out_data), 64'h55);
    check("sel4_err",  64'(b_out_sel_err), 64'd0);
    check("sel4_cnt",  64'(b_err_cnt), 64'd2);
    $display("out-of-range: err_cnt=%0d", b_err_cnt);

    // ---- saturation: three more bad selects, five in total
    b_in_sel = 3'd5;
    for (int k = 0; k < 3; k++) step();
    check("sat_cnt", 64'(b_err_cnt), 64'd3);
    b_in_valid = 1'b0; b_cnt_clr = 1'b1;
    step();
    check("clr_cnt", 64'(b_err_cnt), 64'd0);
    b_in_valid = 1'b1; b_in_sel = 3'd6;
    step();
    check("clr_inc_cnt", 64'(b_err_cnt), 64'd1);
    $display("saturation/clear: err_cnt=%0d", b_err_cnt);
    b_in_valid = 1'b0;
    step();
    b_cnt_clr = 1'b0;
    check("soak_start_empty", 64'(b_out_valid), 64'd0);

    // ---- random soak against a scoreboard
    ref_cnt = 2'd0;
    for (int i = 0; i < 20000; i++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_sel    = 3'($urandom_range(0, 7));
      rnd         = {$urandom, $urandom};
      b_in_data   = rnd[39:0];
      b_cnt_clr   = ($urandom_range(0, 31) == 0);
      push    = b_in_valid && b_in_ready;
      pop     = b_out_valid && b_out_ready;
      stalled = b_out_valid && !b_out_ready;
      held_data = b_out_data;
      held_err  = b_out_sel_err;
      sel_i = int'(b_in_sel);
      if (sel_i < 5) exp_entry = {b_in_data[sel_i*8 +: 8], 1'b0};
      else           exp_entry = {8'hEE, 1'b1};
      step();
      if (pop && sb_q.size() != 0) void'(sb_q.pop_front());
      if (push) sb_q.push_back(exp_entry);
      if (b_cnt_clr)
        ref_cnt = (push && sel_i >= 5) ? 2'd1 : 2'd0;
      else if (push && sel_i >= 5 && ref_cnt != 2'd3)
        ref_cnt = ref_cnt + 2'd1;
      check("soak_valid", 64'(b_out_valid), 64'(sb_q.size() != 0));
      check("soak_ready", 64'(b_in_ready), 64'(sb_q.size() != 2));
      if (sb_q.size() != 0)
        check("soak_head", 64'({b_out_data, b_out_sel_err}), 64'(sb_q[0]));
      if (stalled)
        check("soak_stall", 64'({b_out_data, b_out_sel_err}), 64'({held_data, held_err}));
      check("soak_cnt", 64'(b_err_cnt), 64'(ref_cnt));
    end
    $display("soak: 20000 cycles, final err_cnt=%0d", b_err_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
